// File: rtl/spec_free_list.sv
// Speculative physical-register free list: circular FIFO of preg indices feeding the
// rename lanes, refilled at commit and restored from the architectural list on flush.
module spec_free_list #(
    parameter int PHY_REG_NUM  = 64,
    parameter int RENAME_WIDTH = 2,
    parameter int COMMIT_WIDTH = 2,
    localparam int PW = $clog2(PHY_REG_NUM),
    localparam int CW = $clog2(PHY_REG_NUM + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic [PW-1:0]                    arch_head_i,
    input  logic [PW-1:0]                    arch_tail_i,
    input  logic [CW-1:0]                    arch_cnt_i,
    input  logic [RENAME_WIDTH-1:0]          alloc_valid_i,
    output logic                             alloc_ready_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]  alloc_preg_o,
    input  logic [COMMIT_WIDTH-1:0]          free_valid_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]  free_preg_i,
    output logic [CW-1:0]                    free_cnt_o
);

    logic [PW-1:0] mem [PHY_REG_NUM];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] cnt_q;

    logic [PW-1:0] alloc_off;
    logic [PW-1:0] free_off;
    logic [PW-1:0] free_idx [COMMIT_WIDTH];
    logic          alloc_fire;
    logic [CW:0]   cnt_sum;

    // Lanes are packed by prefix popcount so holes in the valid mask consume no entries.
    always_comb begin
        alloc_ready_o = !flush_i && (cnt_q >= CW'(RENAME_WIDTH));
        alloc_fire    = alloc_ready_o && (|alloc_valid_i);
        alloc_off     = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            alloc_preg_o[k] = mem[tail_q + alloc_off];
            alloc_off       = alloc_off + PW'(alloc_valid_i[k]);
        end
        free_off = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            free_idx[k] = head_q + free_off;
            free_off    = free_off + PW'(free_valid_i[k]);
        end
        cnt_sum = {1'b0, cnt_q} + (CW+1)'(free_off)
                  - (alloc_fire ? (CW+1)'(alloc_off) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHY_REG_NUM; i++) begin
                mem[i] <= PW'(i);
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CW'(PHY_REG_NUM);
        end else begin
            // Releases land even in a flush cycle; the arch pointers already account for them.
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (free_valid_i[k]) begin
                    mem[free_idx[k]] <= free_preg_i[k];
                end
            end
            if (flush_i) begin
                head_q <= arch_head_i;
                tail_q <= arch_tail_i;
                cnt_q  <= arch_cnt_i;
            end else begin
                head_q <= head_q + free_off;
                if (alloc_fire) begin
                    tail_q <= tail_q + alloc_off;
                end
                cnt_q <= cnt_sum[CW-1:0];
            end
        end
    end

    assign free_cnt_o = cnt_q;

    // Releasing more pregs than were handed out is a commit-side protocol error.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !flush_i |-> (cnt_sum <= (CW+1)'(PHY_REG_NUM)));

endmodule

// File: tb/tb_spec_free_list.sv
// Scoreboard bench for spec_free_list: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_spec_free_list;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic [5:0]       arch_head_i;
    logic [5:0]       arch_tail_i;
    logic [6:0]       arch_cnt_i;
    logic [1:0]       alloc_valid_i;
    logic             alloc_ready_o;
    logic [1:0][5:0]  alloc_preg_o;
    logic [1:0]       free_valid_i;
    logic [1:0][5:0]  free_preg_i;
    logic [6:0]       free_cnt_o;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0] v;
        bit         rdy;
        int         cnt;
        int         p0;
        int         p1;
    } exp_t;

    exp_t sb[$];

    spec_free_list dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .arch_head_i   (arch_head_i),
        .arch_tail_i   (arch_tail_i),
        .arch_cnt_i    (arch_cnt_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_preg_o  (alloc_preg_o),
        .free_valid_i  (free_valid_i),
        .free_preg_i   (free_preg_i),
        .free_cnt_o    (free_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ready", int'(alloc_ready_o), int'(e.rdy));
            chk("free_cnt", int'(free_cnt_o), e.cnt);
            if (e.rdy) begin
                if (e.v[0]) chk("preg_lane0", int'(alloc_preg_o[0]), e.p0);
                if (e.v[1]) chk("preg_lane1", int'(alloc_preg_o[1]), e.p1);
            end
        end
    end

    task automatic step(input logic [1:0] v, input bit erdy, input int ecnt,
                        input int ep0 = 0, input int ep1 = 0,
                        input logic [1:0] fv = 2'b00, input int fp0 = 0, input int fp1 = 0,
                        input bit fl = 1'b0);
        exp_t e;
        alloc_valid_i  = v;
        free_valid_i   = fv;
        free_preg_i[0] = 6'(fp0);
        free_preg_i[1] = 6'(fp1);
        flush_i        = fl;
        e.v = v; e.rdy = erdy; e.cnt = ecnt; e.p0 = ep0; e.p1 = ep1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        arch_head_i = '0;
        arch_tail_i = '0;
        arch_cnt_i = '0;
        alloc_valid_i = '0;
        free_valid_i = '0;
        free_preg_i = '0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three full-width allocations from reset
        step(2'b11, 1, 64, 0, 1);
        step(2'b11, 1, 62, 2, 3);
        step(2'b11, 1, 60, 4, 5);
        // only lane 1 valid: it takes the preg at tail
        step(2'b10, 1, 58, 0, 6);
        step(2'b00, 1, 57);
        // drain to one free entry
        for (int j = 0; j < 28; j++) step(2'b11, 1, 57 - 2*j, 7 + 2*j, 8 + 2*j);
        // starved with a single lane; freed preg 40 only usable next cycle
        step(2'b01, 0, 1, 0, 0, 2'b01, 40, 0);
        step(2'b01, 1, 2, 63, 0);
        // refill slots 1..62 with their own ids, head walks to 63
        for (int j = 0; j < 31; j++)
            step(2'b00, (1 + 2*j) >= 2, 1 + 2*j, 0, 0, 2'b11, 1 + 2*j, 2 + 2*j);
        // release straddling 63 -> 0 while allocating (reads see pre-write mem)
        step(2'b11, 1, 63, 40, 1, 2'b11, 12, 13);
        for (int j = 0; j < 30; j++) step(2'b11, 1, 63 - 2*j, 2 + 2*j, 3 + 2*j);
        step(2'b01, 1, 3, 62, 0);
        // allocation straddling 63 -> 0 returns the wrapped releases
        step(2'b11, 1, 2, 12, 13);
        step(2'b01, 0, 0);
        // flush drops the alloc and restores arch pointers
        arch_head_i = 6'd5;
        arch_tail_i = 6'd9;
        arch_cnt_i  = 7'd60;
        step(2'b11, 0, 0, 0, 0, 2'b00, 0, 0, 1'b1);
        arch_head_i = '0;
        arch_tail_i = '0;
        arch_cnt_i  = '0;
        step(2'b11, 1, 60, 9, 10);
        for (int j = 0; j < 24; j++) step(2'b11, 1, 58 - 2*j, 11 + 2*j, 12 + 2*j);
        // simultaneous alloc 2 + free 2 keeps count
        step(2'b11, 1, 10, 59, 60, 2'b11, 20, 21);
        step(2'b11, 1, 10, 61, 62);
        step(2'b00, 1, 8);

        // asynchronous reset mid-cycle
        alloc_valid_i = '0;
        free_valid_i  = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", int'(alloc_ready_o), 1);
        chk("async_rst_cnt", int'(free_cnt_o), 64);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2'b11, 1, 64, 0, 1);
        step(2'b00, 1, 62);

        @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
